// File: rtl/prefetch_fifo.sv
// Prefetch byte FIFO between icache and the instruction decoder.
// Holds up to DEPTH entries of 16 code bytes each. The decoder sees the
// unconsumed bytes of the oldest entry, realigned to byte 0, and may consume
// a variable number of bytes per cycle.
module prefetch_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pr_reset,
  input  logic          prefetchfifo_write_do,
  input  logic [135:0]  prefetchfifo_write_data,
  output logic [AW:0]   prefetchfifo_used,
  output logic          prefetchfifo_overflow,
  output logic          fetch_valid,
  output logic [127:0]  fetch_data,
  output logic [4:0]    fetch_length,
  input  logic          fetch_accept_do,
  input  logic [4:0]    fetch_accept_length
);

  localparam logic [AW:0]   UsedFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   UsedOne  = 1;
  localparam logic [AW-1:0] PtrOne   = 1;

  // Entry storage; contents need no reset since used_q gates every read.
  logic [127:0] mem_data [DEPTH];
  logic [4:0]   mem_cnt  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   used_q, used_d;
  logic [3:0]    head_off_q, head_off_d;
  logic          overflow_q, overflow_d;

  logic          flush;
  logic [4:0]    wr_cnt_raw;
  logic [4:0]    wr_cnt;
  logic [127:0]  wr_data_masked;
  logic          wr_valid;
  logic          wr_accept;
  logic          wr_en;
  logic          consume;
  logic          pop;
  logic          advance;
  logic [4:0]    head_cnt;
  logic [127:0]  head_data;

  // Reserved entry bits are intentionally ignored.
  logic unused_rsvd;
  assign unused_rsvd = ^prefetchfifo_write_data[135:133];

  assign flush      = rst | pr_reset;
  assign wr_cnt_raw = prefetchfifo_write_data[132:128];
  assign head_cnt   = mem_cnt[rd_ptr_q];
  assign head_data  = mem_data[rd_ptr_q];

  // Clamp the byte count and zero bytes beyond it so fetch_data is zero-filled.
  always_comb begin
    wr_cnt         = (wr_cnt_raw > 5'd16) ? 5'd16 : wr_cnt_raw;
    wr_data_masked = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < wr_cnt) begin
        wr_data_masked[8*i +: 8] = prefetchfifo_write_data[8*i +: 8];
      end
    end
  end

  // Head view: realign the unconsumed bytes of the oldest entry to byte 0.
  always_comb begin
    fetch_valid  = (used_q != '0);
    fetch_length = '0;
    fetch_data   = '0;
    if (fetch_valid) begin
      fetch_length = head_cnt - {1'b0, head_off_q};
      fetch_data   = head_data >> {head_off_q, 3'b000};
    end
  end

  // Consume/write decisions and next-state values.
  always_comb begin
    consume   = fetch_accept_do && fetch_valid && (fetch_accept_length != '0);
    // Over-consumption saturates at the entry boundary.
    pop       = consume && (fetch_accept_length >= fetch_length);
    advance   = consume && !pop;
    wr_valid  = prefetchfifo_write_do && (wr_cnt_raw != '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    wr_accept = wr_valid && ((used_q < UsedFull) || pop);
    wr_en     = wr_accept && !flush;

    wr_ptr_d   = wr_accept ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    head_off_d = head_off_q;
    if (pop) begin
      head_off_d = '0;
    end else if (advance) begin
      head_off_d = head_off_q + fetch_accept_length[3:0];
    end

    used_d = used_q;
    if (wr_accept && !pop) begin
      used_d = used_q + UsedOne;
    end else if (pop && !wr_accept) begin
      used_d = used_q - UsedOne;
    end

    overflow_d = wr_valid && !wr_accept;
  end

  // Pointer, occupancy and offset registers; flush wins over write and consume.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      used_q     <= '0;
      head_off_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      used_q     <= used_d;
      head_off_q <= head_off_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= wr_data_masked;
      mem_cnt[wr_ptr_q]  <= wr_cnt;
    end
  end

  assign prefetchfifo_used     = used_q;
  assign prefetchfifo_overflow = overflow_q;

endmodule

// File: tb/tb_prefetch_fifo.sv
// Bench for prefetch_fifo: directed scenarios plus a random stream checked
// against a queue-of-entries reference model.
module tb_prefetch_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          pr_reset;
  logic          prefetchfifo_write_do;
  logic [135:0]  prefetchfifo_write_data;
  logic [AW:0]   prefetchfifo_used;
  logic          prefetchfifo_overflow;
  logic          fetch_valid;
  logic [127:0]  fetch_data;
  logic [4:0]    fetch_length;
  logic          fetch_accept_do;
  logic [4:0]    fetch_accept_length;

  int total = 0;
  int bad   = 0;

  // Reference model: each queued entry holds its remaining bytes at byte 0.
  logic [127:0] m_data[$];
  int           m_len[$];
  logic         m_ovf = 1'b0;

  always #5 clk = ~clk;

  prefetch_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .pr_reset                (pr_reset),
    .prefetchfifo_write_do   (prefetchfifo_write_do),
    .prefetchfifo_write_data (prefetchfifo_write_data),
    .prefetchfifo_used       (prefetchfifo_used),
    .prefetchfifo_overflow   (prefetchfifo_overflow),
    .fetch_valid             (fetch_valid),
    .fetch_data              (fetch_data),
    .fetch_length            (fetch_length),
    .fetch_accept_do         (fetch_accept_do),
    .fetch_accept_length     (fetch_accept_length)
  );

  function automatic logic [127:0] keep_bytes(input logic [127:0] d, input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (i < n) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [135:0] mk_entry(input int cnt, input logic [127:0] d);
    logic [135:0] e;
    e = {3'($urandom), 5'(cnt), d};
    return e;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW:0] exp_used();
    return (AW + 1)'(m_data.size());
  endfunction

  function automatic logic [4:0] exp_len();
    return (m_data.size() != 0) ? 5'(m_len[0]) : 5'd0;
  endfunction

  function automatic logic [127:0] exp_data();
    return (m_data.size() != 0) ? m_data[0] : 128'd0;
  endfunction

  // Apply one cycle of inputs, advance the model, and return #1 after the edge.
  task automatic drive(input logic wdo, input logic [135:0] wd, input logic ado,
                       input logic [4:0] alen, input logic prr, input logic rr);
    int  cnt;
    int  pre;
    bit  popped;
    rst = rr;
    pr_reset = prr;
    prefetchfifo_write_do = wdo;
    prefetchfifo_write_data = wd;
    fetch_accept_do = ado;
    fetch_accept_length = alen;
    m_ovf = 1'b0;
    if (prr || rr) begin
      m_data.delete();
      m_len.delete();
    end else begin
      pre = m_data.size();
      popped = 0;
      if (ado && pre > 0 && alen != 0) begin
        if (int'(alen) >= m_len[0]) begin
          void'(m_data.pop_front());
          void'(m_len.pop_front());
          popped = 1;
        end else begin
          m_data[0] = m_data[0] >> (8 * int'(alen));
          m_len[0] = m_len[0] - int'(alen);
        end
      end
      cnt = int'(wd[132:128]);
      if (wdo && cnt != 0) begin
        if (cnt > 16) cnt = 16;
        if (pre < DEPTH || popped) begin
          m_data.push_back(keep_bytes(wd[127:0], cnt));
          m_len.push_back(cnt);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pr_reset = 1'b0;
    prefetchfifo_write_do = 1'b0;
    prefetchfifo_write_data = '0;
    fetch_accept_do = 1'b0;
    fetch_accept_length = '0;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
    total++; if (prefetchfifo_used !== '0) begin
      bad++; $display("FAIL reset_used got=%0d want=0", prefetchfifo_used); end
    total++; if (prefetchfifo_overflow !== 1'b0) begin
      bad++; $display("FAIL reset_ovf got=%b want=0", prefetchfifo_overflow); end
    total++; if (fetch_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", fetch_valid); end
    total++; if (fetch_length !== 5'd0) begin
      bad++; $display("FAIL reset_len got=%0d want=0", fetch_length); end
    total++; if (fetch_data !== 128'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", fetch_data); end
  endtask

  task automatic test_write_consume();
    logic [127:0] seq;
    for (int i = 0; i < 16; i++) seq[8*i +: 8] = 8'(i);
    drive(1'b1, mk_entry(16, seq), 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (fetch_valid !== 1'b1 || fetch_length !== 5'd16) begin
      bad++; $display("FAIL wr_first valid/len got=%b/%0d want=1/16", fetch_valid, fetch_length); end
    total++; if (fetch_data[7:0] !== 8'h00 || prefetchfifo_used !== 4'd1) begin
      bad++; $display("FAIL wr_first byte/used got=%h/%0d want=00/1", fetch_data[7:0],
                      prefetchfifo_used); end
    drive(1'b0, '0, 1'b1, 5'd3, 1'b0, 1'b0);
    total++; if (fetch_length !== 5'd13 || fetch_data[7:0] !== 8'h03) begin
      bad++; $display("FAIL consume3 len/byte got=%0d/%h want=13/03", fetch_length,
                      fetch_data[7:0]); end
    drive(1'b0, '0, 1'b1, 5'd5, 1'b0, 1'b0);
    total++; if (fetch_length !== 5'd8 || fetch_data !== {64'd0, 64'h0F0E0D0C0B0A0908}) begin
      bad++; $display("FAIL consume5 len/data got=%0d/%h want=8/0f0e0d0c0b0a0908",
                      fetch_length, fetch_data); end
    drive(1'b0, '0, 1'b1, 5'd16, 1'b0, 1'b0);
    total++; if (fetch_valid !== 1'b0 || prefetchfifo_used !== 4'd0) begin
      bad++; $display("FAIL consume16 valid/used got=%b/%0d want=0/0", fetch_valid,
                      prefetchfifo_used); end
  endtask

  task automatic test_overflow();
    logic [127:0] tag;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, mk_entry(16, rnd128()), 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (prefetchfifo_used !== 4'd8) begin
      bad++; $display("FAIL fill_used got=%0d want=8", prefetchfifo_used); end
    drive(1'b1, mk_entry(16, rnd128()), 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (prefetchfifo_overflow !== 1'b1 || prefetchfifo_used !== 4'd8) begin
      bad++; $display("FAIL ovf_pulse ovf/used got=%b/%0d want=1/8", prefetchfifo_overflow,
                      prefetchfifo_used); end
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (prefetchfifo_overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_one_cycle got=%b want=0", prefetchfifo_overflow); end
    tag = 128'hA5A5_0000_1111_2222_3333_4444_5555_9999;
    drive(1'b1, mk_entry(16, tag), 1'b1, 5'd16, 1'b0, 1'b0);
    total++; if (prefetchfifo_used !== 4'd8 || prefetchfifo_overflow !== 1'b0) begin
      bad++; $display("FAIL full_pop_write used/ovf got=%0d/%b want=8/0", prefetchfifo_used,
                      prefetchfifo_overflow); end
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (fetch_data !== exp_data() || fetch_length !== exp_len()) begin
        bad++; $display("FAIL drain[%0d] data/len got=%h/%0d want=%h/%0d", i, fetch_data,
                        fetch_length, exp_data(), exp_len()); end
      drive(1'b0, '0, 1'b1, 5'd16, 1'b0, 1'b0);
    end
    total++; if (prefetchfifo_used !== 4'd0) begin
      bad++; $display("FAIL drain_empty got=%0d want=0", prefetchfifo_used); end
  endtask

  task automatic test_count_edges();
    drive(1'b1, mk_entry(0, rnd128()), 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (prefetchfifo_used !== 4'd0 || fetch_valid !== 1'b0
                 || prefetchfifo_overflow !== 1'b0) begin
      bad++; $display("FAIL count0 used/valid/ovf got=%0d/%b/%b want=0/0/0",
                      prefetchfifo_used, fetch_valid, prefetchfifo_overflow); end
    drive(1'b1, mk_entry(20, {128{1'b1}}), 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (fetch_length !== 5'd16 || fetch_data !== {128{1'b1}}) begin
      bad++; $display("FAIL count20 len/data got=%0d/%h want=16/all-ones", fetch_length,
                      fetch_data); end
    drive(1'b1, mk_entry(5, {128{1'b1}}), 1'b1, 5'd31, 1'b0, 1'b0);
    total++; if (fetch_length !== 5'd5 || fetch_data !== 128'hFF_FFFF_FFFF) begin
      bad++; $display("FAIL count5_zero_fill len/data got=%0d/%h want=5/ffffffffff",
                      fetch_length, fetch_data); end
    drive(1'b0, '0, 1'b1, 5'd0, 1'b0, 1'b0);
    total++; if (fetch_length !== 5'd5 || prefetchfifo_used !== 4'd1) begin
      bad++; $display("FAIL accept_len0 len/used got=%0d/%0d want=5/1", fetch_length,
                      prefetchfifo_used); end
    drive(1'b0, '0, 1'b1, 5'd2, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 5'd9, 1'b0, 1'b0);
    total++; if (fetch_valid !== 1'b0 || prefetchfifo_used !== 4'd0) begin
      bad++; $display("FAIL overconsume valid/used got=%b/%0d want=0/0", fetch_valid,
                      prefetchfifo_used); end
    drive(1'b0, '0, 1'b1, 5'd4, 1'b0, 1'b0);
    total++; if (fetch_valid !== 1'b0 || fetch_length !== 5'd0) begin
      bad++; $display("FAIL accept_empty valid/len got=%b/%0d want=0/0", fetch_valid,
                      fetch_length); end
  endtask

  task automatic test_stream();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      logic       wdo, ado, prr;
      logic [4:0] alen;
      int         cnt;
      wdo  = ($urandom_range(0, 9) < 6);
      ado  = ($urandom_range(0, 9) < 6);
      prr  = ($urandom_range(0, 59) == 0);
      alen = 5'($urandom_range(0, 20));
      cnt  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 16);
      drive(wdo, mk_entry(cnt, rnd128()), ado, alen, prr, 1'b0);
      total++; if (prefetchfifo_used !== exp_used() || prefetchfifo_overflow !== m_ovf) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL stream[%0d] used/ovf got=%0d/%b want=%0d/%b", c,
                                prefetchfifo_used, prefetchfifo_overflow, exp_used(), m_ovf);
      end
      total++; if (fetch_valid !== (m_data.size() != 0) || fetch_length !== exp_len()
                   || fetch_data !== exp_data()) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL stream[%0d] valid/len/data got=%b/%0d/%h want=%b/%0d/%h",
                                c, fetch_valid, fetch_length, fetch_data,
                                (m_data.size() != 0), exp_len(), exp_data());
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b1, mk_entry(16, rnd128()), 1'b0, 5'd0, 1'b0, 1'b0);
      total++; if (prefetchfifo_used !== 4'd5) begin
        bad++; $display("FAIL flush%0d_pre used got=%0d want=5", k, prefetchfifo_used); end
      drive(1'b1, mk_entry(16, rnd128()), 1'b1, 5'd4, (k == 0), (k == 1));
      total++; if (prefetchfifo_used !== 4'd0 || fetch_valid !== 1'b0
                   || prefetchfifo_overflow !== 1'b0 || fetch_length !== 5'd0) begin
        bad++; $display("FAIL flush%0d used/valid/ovf/len got=%0d/%b/%b/%0d want=0/0/0/0", k,
                        prefetchfifo_used, fetch_valid, prefetchfifo_overflow, fetch_length);
      end
    end
    // Flush while full with a write that would otherwise overflow.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, mk_entry(16, rnd128()), 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, mk_entry(16, rnd128()), 1'b0, 5'd0, 1'b1, 1'b0);
    total++; if (prefetchfifo_used !== 4'd0 || prefetchfifo_overflow !== 1'b0) begin
      bad++; $display("FAIL flush_full used/ovf got=%0d/%b want=0/0", prefetchfifo_used,
                      prefetchfifo_overflow); end
  endtask

  initial begin
    rst = 1'b1;
    pr_reset = 1'b0;
    prefetchfifo_write_do = 1'b0;
    prefetchfifo_write_data = '0;
    fetch_accept_do = 1'b0;
    fetch_accept_length = '0;
    test_reset();
    test_write_consume();
    test_overflow();
    test_count_edges();
    test_stream();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prefetch_fifo.md
# prefetch_fifo

Byte-stream buffer between the instruction cache and the instruction decoder. It accepts 136-bit prefetch entries from icache, each holding up to 16 code bytes plus a byte count, and stores them in order. It presents the oldest unconsumed bytes, realigned to byte 0, to the decoder, which consumes a variable number of bytes per cycle. It also reports occupancy to the prefetch unit for flow control, and it is flushed by `pr_reset`.

## Interface
- `DEPTH`, default 8: number of entries, power of two, minimum 2.
- `AW`, default 3: log2(DEPTH).
- `clk`  in  1  clock; all state is updated on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pr_reset`  in  1  pipeline flush; synchronous.
- `prefetchfifo_write_do`  in  1  write strobe from icache.
- `prefetchfifo_write_data`  in  136  entry format:
  - [127:0] code bytes, byte 0 in [7:0].
  - [132:128] valid byte count.
  - [135:133] reserved, ignored.
- `prefetchfifo_used`  out  AW+1  number of stored entries, 0..DEPTH.
- `prefetchfifo_overflow`  out  1  one-cycle pulse when a write is dropped.
- `fetch_valid`  out  1  head entry has at least 1 unconsumed byte.
- `fetch_data`  out  128  unconsumed head bytes; next byte is in [7:0]; bytes above `fetch_length` are zero.
- `fetch_length`  out  5  unconsumed byte count of the head entry, 1..16; 0 when `fetch_valid`=0.
- `fetch_accept_do`  in  1  decoder consumes bytes this cycle.
- `fetch_accept_length`  in  5  number of bytes consumed, 1..16.

## Operation
- Storage: circular array of DEPTH entries, each holding 128 data bits and a 5-bit count. Pointers `wr_ptr`/`rd_ptr` are AW bits and wrap modulo DEPTH. A `used` counter is AW+1 bits. A head offset register `head_off` [3:0] records bytes already consumed from the head entry.
- Write path:
  - A write with count 0 is discarded; no state changes and no overflow pulse.
  - A count of 17..31 is clamped to 16 before storing.
  - A write is accepted when `used` < DEPTH, or when `used` = DEPTH and the same cycle pops the head.
  - Otherwise the write is dropped and `prefetchfifo_overflow` pulses.
- Output (combinational from registered state):
  - `fetch_valid` = (`used` != 0).
  - `fetch_length` = head count − `head_off`.
  - `fetch_data` = head data >> (8·`head_off`), zero-filled.
- Consume, when `fetch_accept_do` && `fetch_valid`:
  - If `fetch_accept_length` >= `fetch_length`: pop the head, advance `rd_ptr`, set `head_off` to 0. Over-consumption saturates at the entry boundary and never spills into the next entry.
  - Otherwise: `head_off` += `fetch_accept_length`.
  - `fetch_accept_length` = 0 is treated as no consume.
  - `fetch_accept_do` while `fetch_valid`=0 is ignored.
- `used` update: next = `used` + write_accepted − pop.
- Flush: `rst` or `pr_reset` clears `used`, `wr_ptr`, `rd_ptr` and `head_off`. Flush has priority over a write and a consume in the same cycle; both are lost and no overflow pulse is produced.
- No internal state machine beyond the pointers, counter and offset; there are no multi-cycle handshakes.

## Timing
- Reset values: `prefetchfifo_used`=0, `prefetchfifo_overflow`=0, `fetch_valid`=0, `fetch_length`=0, `fetch_data`=0.
- Write-to-output latency is 1 cycle: a write to an empty FIFO at edge N gives `fetch_valid`=1 after edge N. There is no same-cycle bypass.
- A consume at edge N is reflected in the `fetch_*` outputs after edge N, so the next head is visible with zero bubble.
- `prefetchfifo_used` is registered and updated one edge after the write or pop.
- `prefetchfifo_overflow` is registered and asserted for the cycle following the dropped write.
- Throughput: one write and one pop per cycle, sustained, at any occupancy including full.

## Test plan
- Reset, then write {count=16, bytes 0x00..0x0F}: next cycle `fetch_valid`=1, `fetch_length`=16, `fetch_data`[7:0]=0x00, `prefetchfifo_used`=1.
- Same entry, consume 3, then 5: `fetch_length` goes 13 then 8, `fetch_data`[7:0] goes 0x03 then 0x08; consume 16 → pop, `fetch_valid`=0, `used`=0.
- Fill 8 entries, then write a 9th without consume: `prefetchfifo_overflow`=1 for one cycle and `used` stays 8. Then a write together with a full pop: accepted, `used` stays 8, and the 9th entry later appears in order.
- Write count=0 → ignored; write count=20 → stored as 16.
- Stream 20 entries with interleaved consumes: pointer wrap-around preserves byte order exactly against a reference model.
- With 5 entries stored, assert `pr_reset` together with a write and a consume: next cycle `used`=0, `fetch_valid`=0, no overflow pulse. Repeat with `rst` and check identical results.
